// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// parity rule used by the receiver, the TX model and the scoreboard.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  // par_typ=0 yields XNOR-reduce, par_typ=1 yields XOR-reduce of the data.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic par_typ);
    return par_typ ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line; both flops reset to
// the idle (high) level so reset never looks like a start bit.
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_async,
  output logic rx_sync
);

  logic rx_meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_async;
      rx_sync <= rx_meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchroniser first.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic [DATA_BITS-1:0] P_DATA,
  output logic                 DATA_VALID,
  output logic                 PAR_ERR,
  output logic                 STOP_ERR,
  output logic                 Busy
);
  import uart_pkg::*;

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  ALL_BITS    = BIT_W'(DATA_BITS);

  logic rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .rx_async (RX_IN),
    .rx_sync  (rx)
  );
`else
  assign rx = RX_IN;
`endif

  uart_state_e          state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic                 par_err_q;

  logic              sample;
  logic              wrap;
  logic              data_done;
  logic [TICK_W-1:0] tick_nxt;

  assign sample   = (tick == SAMPLE_TICK);
  assign wrap     = (tick == LAST_TICK);
  assign tick_nxt = wrap ? '0 : tick + TICK_W'(1);
  // With one clock per bit the last sample and the wrap share an edge, so the
  // counter has not yet advanced; otherwise the sample came earlier in the bit.
  assign data_done = sample ? (bit_cnt == LAST_BIT) : (bit_cnt == ALL_BITS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            bit_cnt   <= '0;
            Busy      <= 1'b1;
            // The detecting edge counts as tick 0 of the start bit.
            if (CLKS_PER_BIT == 1) begin
              state <= DATA;
            end else begin
              state <= START;
              tick  <= TICK_W'(1);
            end
          end
        end
        START: begin
          tick <= tick_nxt;
          if (sample && rx) begin
            state <= IDLE;
            tick  <= '0;
            Busy  <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          tick <= tick_nxt;
          if (sample) begin
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + BIT_W'(1);
          end
          if (wrap && data_done) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          tick <= tick_nxt;
          if (sample) begin
            par_err_q <= (rx != parity_bit(shift_reg, par_typ_q));
          end
          if (wrap) begin
            state <= STOP;
          end
        end
        STOP: begin
          tick <= tick_nxt;
          if (sample) begin
            P_DATA     <= shift_reg;
            DATA_VALID <= 1'b1;
            PAR_ERR    <= par_err_q;
            STOP_ERR   <= ~rx;
            tick       <= '0;
            // Leaving at the sample point resynchronises to the next start edge.
            if (rx) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          tick <= '0;
          if (rx) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
